timekeeper: RTL

TIMEKEEPER -- requirements
Module: timekeeper

---
 rtl/timekeeper_if.sv | 27 ++
 rtl/timekeeper.sv | 132 +++++++++++++
 2 files changed

// File: rtl/timekeeper_if.sv
// Control pulses and time/display outputs of the timekeeper, bundled for port grouping.
// The master side drives the pulses; the timekeeper sits on the slave side.
interface timekeeper_if;
    logic       set;
    logic       up;
    logic       down;
    logic       fmt_tog;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [4:0] disp_hour;
    logic       pm;
    logic       fmt12;
    logic [1:0] field;
    logic       sec_tick;
    logic       day_tick;

    modport master (
        output set, up, down, fmt_tog,
        input  hour, min, sec, disp_hour, pm, fmt12, field, sec_tick, day_tick
    );

    modport slave (
        input  set, up, down, fmt_tog,
        output hour, min, sec, disp_hour, pm, fmt12, field, sec_tick, day_tick
    );
endinterface

// File: rtl/timekeeper.sv
// Hours/minutes/seconds clock with a prescaler, a four-state set menu driven by
// set/up/down pulses, and a 12h/24h display decode.
module timekeeper #(
    parameter int TICKS_PER_SEC = 2500,
    parameter bit FMT12_DEFAULT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    timekeeper_if.slave  bus
);
    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       hour_reg;
    logic [5:0]       min_reg;
    logic [5:0]       sec_reg;
    logic             fmt12_reg;
    logic             sec_tick_reg;
    logic             day_tick_reg;
    logic [4:0]       disp_hour_next;

    // A set pulse wins over up/down, and up+down together cancel out.
    logic adj_up;
    logic adj_dn;
    assign adj_up = bus.up & ~bus.down & ~bus.set;
    assign adj_dn = bus.down & ~bus.up & ~bus.set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            hour_reg     <= '0;
            min_reg      <= '0;
            sec_reg      <= '0;
            fmt12_reg    <= FMT12_DEFAULT;
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
            if (bus.fmt_tog)
                fmt12_reg <= ~fmt12_reg;

            if (bus.set) begin
                // Leaving or entering a set state always restarts the prescaler.
                cnt_reg <= '0;
                case (state_reg)
                    RUN:      state_reg <= SET_HOUR;
                    SET_HOUR: state_reg <= SET_MIN;
                    SET_MIN:  state_reg <= SET_SEC;
                    default:  state_reg <= RUN;
                endcase
            end else begin
                case (state_reg)
                    RUN: begin
                        if (cnt_reg == CNT_MAX) begin
                            cnt_reg      <= '0;
                            sec_tick_reg <= 1'b1;
                            if (sec_reg == 6'd59) begin
                                sec_reg <= '0;
                                if (min_reg == 6'd59) begin
                                    min_reg <= '0;
                                    if (hour_reg == 5'd23) begin
                                        hour_reg     <= '0;
                                        day_tick_reg <= 1'b1;
                                    end else begin
                                        hour_reg <= hour_reg + 5'd1;
                                    end
                                end else begin
                                    min_reg <= min_reg + 6'd1;
                                end
                            end else begin
                                sec_reg <= sec_reg + 6'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    SET_HOUR: begin
                        cnt_reg <= '0;
                        if (adj_up)
                            hour_reg <= (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                        else if (adj_dn)
                            hour_reg <= (hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1;
                    end
                    SET_MIN: begin
                        cnt_reg <= '0;
                        if (adj_up)
                            min_reg <= (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
                        else if (adj_dn)
                            min_reg <= (min_reg == 6'd0) ? 6'd59 : min_reg - 6'd1;
                    end
                    default: begin
                        cnt_reg <= '0;
                        if (adj_up || adj_dn)
                            sec_reg <= '0;
                    end
                endcase
            end
        end
    end

    // Display decode is a pure function of registered hour and flag, so it never lags hour.
    always_comb begin
        disp_hour_next = hour_reg;
        if (fmt12_reg) begin
            if (hour_reg == 5'd0)
                disp_hour_next = 5'd12;
            else if (hour_reg > 5'd12)
                disp_hour_next = hour_reg - 5'd12;
        end
    end

    assign bus.hour      = hour_reg;
    assign bus.min       = min_reg;
    assign bus.sec       = sec_reg;
    assign bus.disp_hour = disp_hour_next;
    assign bus.pm        = fmt12_reg & (hour_reg >= 5'd12);
    assign bus.fmt12     = fmt12_reg;
    assign bus.field     = state_reg;
    assign bus.sec_tick  = sec_tick_reg;
    assign bus.day_tick  = day_tick_reg;
endmodule
